sequential_divider: RTL and testbench
=====================================

# sequential_divider

Iterative restoring unsigned divider, one quotient bit per clock. It is the inverse companion of the team's shift-add sequential multiplier and uses the same Start/Ready operand handshake, so a bench or datapath can drive either block identically. For non-zero divisors it satisfies Dividend == Quotient*Divisor + Remainder, with Remainder < Divisor. It has one clock domain and an asynchronous active-low reset.

## Interface
- N, 4, operand width in bits; legal range 2..32.

- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Dividend  input  N  unsigned numerator; sampled only on an accepted Start.
- Divisor  input  N  unsigned denominator; sampled only on an accepted Start.
- Start  input  1  request; accepted on a rising edge where Ready==1.
- Quotient  output  N  result quotient, registered.
- Remainder  output  N  result remainder, registered.
- Ready  output  1  high = idle, outputs valid, new Start accepted.
- DivByZero  output  1  high with Ready when the last accepted Divisor was 0.

## Operation
- States:
  - IDLE: Ready=1.
  - RUN: Ready=0, N iterations.
- Transitions:
  - IDLE→RUN on Start && Divisor!=0.
  - IDLE→IDLE on Start && Divisor==0 (divide-by-zero path).
  - RUN→IDLE when the iteration counter reaches 0.
- Accept edge (IDLE, Start=1, Divisor≠0):
  - Capture Dividend into the quotient shift register Q.
  - Capture Divisor into register D.
  - Clear the partial remainder P (N+1 bits).
  - Load counter = N.
  - Clear DivByZero.
- RUN step, per edge:
  - {P,Q} shifted left 1 (MSB of Q enters P[0]).
  - T = P_shifted − {1'b0,D}, computed N+1 wide.
  - If T[N]==0: P=T and Q[0]=1.
  - Else: P=P_shifted and Q[0]=0.
  - Counter decrements by 1.
- Quotient=Q and Remainder=P[N-1:0], both driven continuously from registers. Values are architecturally valid only while Ready=1.
- Divide by zero (IDLE, Start=1, Divisor==0), resolved on the accept edge with no RUN:
  - Quotient = all ones.
  - Remainder = Dividend.
  - DivByZero=1.
  - Ready stays 1.
- Start while Ready=0 is ignored. Input changes during RUN have no effect because operands are captured.
- Start held high continuously: a new operation is accepted on the first edge after Ready returns to 1. There is no gap cycle beyond that.
- Reset_n low at any time, including mid-RUN:
  - Immediately forces IDLE, Ready=1, Quotient=0, Remainder=0, DivByZero=0, counter=0.
  - An in-flight operation is discarded.

## Timing
- Reset values: Ready=1, Quotient=0, Remainder=0, DivByZero=0.
- Latency, accept on edge k:
  - Ready=0 after edge k.
  - Ready=1 after edge k+N, with final Quotient/Remainder valid in the same cycle.
- Divide by zero: result and DivByZero visible after edge k; Ready never drops.
- Outputs hold their final values until the next accepted Start.
- Throughput: one division per N+1 cycles when Start is held high.
- Timeout bound for benches: 2N+4 cycles, matching the multiplier bench.

## Structure
- Package div_pkg:
  - typedef enum logic {IDLE, RUN} div_state_t.
  - Function for counter width: $clog2(N+1).
- Sub-module div_step (combinational):
  - Inputs: P, Q, D.
  - Outputs: next P, next Q.
  - Implements one shift-compare-subtract iteration.
  - Instantiated once in sequential_divider.
- Top:
  - State register.
  - Counter.
  - Operand/result registers.
  - Divide-by-zero bypass mux.

## Test plan
- N=4, reset then Start with 13/3 → Ready low for 4 cycles; then Q=4, R=1, DivByZero=0.
- 15/1 → Q=15, R=0. 0/5 → Q=0, R=0. 3/9 → Q=0, R=3. Each completes in exactly N cycles.
- 7/0 → after 1 edge: Q=15, R=7, DivByZero=1, Ready never deasserted. A following 8/2 returns Q=4, R=0 and clears DivByZero.
- Accept 14/4, then change Dividend/Divisor and pulse Start during RUN → Start ignored; result is Q=3, R=2.
- Accept 11/2, assert Reset_n low at cycle 2 of RUN → outputs are 0 and Ready=1 immediately. After release, 9/4 → Q=2, R=1.
- Start held high with back-to-back random operands (≥200, plus exhaustive N=4) → every result matches the reference model, and each accept is spaced N+1 cycles apart.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
package div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_t;

    localparam int DIV_DEFAULT_WIDTH = 4;

    // Counter must hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {P,Q} left, trial-subtract D,
// keep the difference and set the quotient bit when it does not go negative.
module div_step #(
    parameter int N = 4
) (
    input  logic [N-1:0] p,
    input  logic [N-1:0] q,
    input  logic [N-1:0] d,
    output logic [N-1:0] p_next,
    output logic [N-1:0] q_next
);

    logic [N:0] p_shift;
    logic [N:0] t;

    always_comb begin
        p_shift = {p, q[N-1]};
        t       = p_shift - {1'b0, d};
        // The partial remainder stays below D, so after the step it fits N bits.
        if (!t[N]) begin
            p_next = t[N-1:0];
            q_next = {q[N-2:0], 1'b1};
        end else begin
            p_next = p_shift[N-1:0];
            q_next = {q[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/sequential_divider.sv
// Iterative unsigned divider, one quotient bit per clock, Start/Ready handshake.
// A zero divisor is resolved on the accept edge without entering RUN.
module sequential_divider
    import div_pkg::*;
#(
    parameter int N = DIV_DEFAULT_WIDTH
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         start,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         ready,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    div_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [N-1:0]  p_reg, p_next;
    logic [N-1:0]  q_reg, q_next;
    logic [N-1:0]  d_reg, d_next;
    logic          dbz_reg, dbz_next;

    logic [N-1:0]  step_p;
    logic [N-1:0]  step_q;

    div_step #(.N(N)) u_step (
        .p      (p_reg),
        .q      (q_reg),
        .d      (d_reg),
        .p_next (step_p),
        .q_next (step_q)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            p_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            p_reg     <= p_next;
            q_reg     <= q_next;
            d_reg     <= d_next;
            dbz_reg   <= dbz_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        p_next     = p_reg;
        q_next     = q_reg;
        d_next     = d_reg;
        dbz_next   = dbz_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    d_next = divisor;
                    if (divisor != '0) begin
                        state_next = RUN;
                        q_next     = dividend;
                        p_next     = '0;
                        cnt_next   = CNT_LOAD;
                        dbz_next   = 1'b0;
                    end else begin
                        // Divide-by-zero bypass: saturated quotient, dividend as remainder.
                        q_next   = '1;
                        p_next   = dividend;
                        dbz_next = 1'b1;
                    end
                end
            end
            RUN: begin
                p_next   = step_p;
                q_next   = step_q;
                cnt_next = cnt_reg - CNT_LAST;
                if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ready       = (state_reg == IDLE);
    assign quotient    = q_reg;
    assign remainder   = p_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_sequential_divider.sv
// Randomised and directed bench for sequential_divider against an arithmetic
// reference (a/b, a%b, and the divide-by-zero convention).
module tb_sequential_divider;

    localparam int N     = 4;
    localparam int BOUND = 2 * N + 4;

    logic         clock;
    logic         reset_n;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         start;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         ready;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int     prev_acc  = 0;
    logic   prev_zero = 1'b0;
    logic   have_prev = 1'b0;

    sequential_divider #(.N(N)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .dividend    (dividend),
        .divisor     (divisor),
        .start       (start),
        .quotient    (quotient),
        .remainder   (remainder),
        .ready       (ready),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b);
        if (b == 0) return '1;
        return a / b;
    endfunction

    function automatic logic [N-1:0] ref_r(input logic [N-1:0] a, input logic [N-1:0] b);
        if (b == 0) return a;
        return a % b;
    endfunction

    task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Count further edges until ready, bounded.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!ready && lat < BOUND) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input int lat);
        check({tag, "_lat"}, lat, (b == 0) ? 0 : N);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_q"}, quotient, ref_q(a, b));
        check({tag, "_r"}, remainder, ref_r(a, b));
        check({tag, "_dbz"}, div_by_zero, (b == 0) ? 1 : 0);
        $display("op %0d/%0d q=%0d r=%0d dbz=%0d lat=%0d", a, b, quotient, remainder, div_by_zero, lat);
    endtask

    task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
        int lat;
        accept(a, b);
        check({tag, "_ready_after_accept"}, ready, (b == 0) ? 1 : 0);
        wait_done(0, lat);
        check_result(tag, a, b, lat);
    endtask

    // Start is held high by the caller; ready is 1 on entry.
    task automatic bb_op(input logic [N-1:0] a, input logic [N-1:0] b);
        int lat;
        int acc;
        dividend = a;
        divisor  = b;
        @(posedge clock);
        #1;
        acc = cyc;
        if (have_prev) check("bb_spacing", acc - prev_acc, prev_zero ? 1 : N + 1);
        wait_done(0, lat);
        check_result("bb", a, b, lat);
        prev_acc  = acc;
        prev_zero = (b == 0);
        have_prev = 1'b1;
    endtask

    initial begin
        int lat;
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        check("reset_ready", ready, 1);
        check("reset_q", quotient, 0);
        check("reset_r", remainder, 0);
        check("reset_dbz", div_by_zero, 0);
        @(negedge clock);
        reset_n = 1'b1;

        do_op("d13_3", 4'd13, 4'd3);
        do_op("d15_1", 4'd15, 4'd1);
        do_op("d0_5", 4'd0, 4'd5);
        do_op("d3_9", 4'd3, 4'd9);
        do_op("d7_0", 4'd7, 4'd0);
        do_op("d8_2", 4'd8, 4'd2);

        // Operand changes and a Start pulse during RUN must be ignored.
        accept(4'd14, 4'd4);
        @(negedge clock);
        dividend = 4'd1;
        divisor  = 4'd1;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(1, lat);
        check_result("midrun", 4'd14, 4'd4, lat);

        // Asynchronous reset in the middle of RUN.
        accept(4'd11, 4'd2);
        @(posedge clock);
        #1;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_ready", ready, 1);
        check("rst_mid_q", quotient, 0);
        check("rst_mid_r", remainder, 0);
        check("rst_mid_dbz", div_by_zero, 0);
        @(negedge clock);
        reset_n = 1'b1;
        do_op("d9_4", 4'd9, 4'd4);

        // Back-to-back with Start held high: exhaustive, then random.
        @(negedge clock);
        start = 1'b1;
        for (int a = 0; a < (1 << N); a++) begin
            for (int b = 0; b < (1 << N); b++) begin
                bb_op(N'(a), N'(b));
            end
        end
        for (int i = 0; i < 200; i++) begin
            bb_op(N'($urandom_range(0, (1 << N) - 1)), N'($urandom_range(0, (1 << N) - 1)));
        end
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
